// File: rtl/seven_seg_pkg.sv
// Shared types and helpers for the seven-segment capture path.
// Holds the select decoder and the hex glyph table.
package seven_seg_pkg;

    localparam int unsigned SEG_W          = 8;
    localparam int unsigned DEF_NUM_DIGITS = 8;
    localparam int unsigned MAX_SEL        = 32;
    localparam int unsigned IDX_W          = 6;

    typedef struct packed {
        logic             valid;
        logic             multi;
        logic [IDX_W-1:0] index;
    } onehot_dec_t;

    // valid: exactly one bit set; multi: two or more; index: lowest set bit.
    function automatic onehot_dec_t onehot_to_index(input logic [MAX_SEL-1:0] sel);
        onehot_dec_t dec;
        logic        found;
        dec   = '0;
        found = 1'b0;
        for (int i = 0; i < MAX_SEL; i++) begin
            if (sel[i]) begin
                if (found) begin
                    dec.multi = 1'b1;
                end else begin
                    dec.index = IDX_W'(i);
                    found     = 1'b1;
                end
            end
        end
        dec.valid = found & ~dec.multi;
        return dec;
    endfunction

    // Active-low segments {dp,g,f,e,d,c,b,a}, decimal point off.
    function automatic logic [SEG_W-1:0] seg_encode(input logic [3:0] value);
        logic [SEG_W-1:0] pattern;
        case (value)
            4'h0: pattern = 8'hC0;
            4'h1: pattern = 8'hF9;
            4'h2: pattern = 8'hA4;
            4'h3: pattern = 8'hB0;
            4'h4: pattern = 8'h99;
            4'h5: pattern = 8'h92;
            4'h6: pattern = 8'h82;
            4'h7: pattern = 8'hF8;
            4'h8: pattern = 8'h80;
            4'h9: pattern = 8'h90;
            4'hA: pattern = 8'h88;
            4'hB: pattern = 8'h83;
            4'hC: pattern = 8'hC6;
            4'hD: pattern = 8'hA1;
            4'hE: pattern = 8'h86;
            default: pattern = 8'h8E;
        endcase
        return pattern;
    endfunction

endpackage

// File: rtl/seven_seg_demux_seg_sample_filter.sv
// Samples the scanned bus and counts how long the sample has stayed unchanged.
// capture is high for exactly one cycle per stable window of SETTLE samples.
module seg_sample_filter
    import seven_seg_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = DEF_NUM_DIGITS,
    parameter int unsigned SETTLE     = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [SEG_W-1:0]      seg_in,
    input  logic [NUM_DIGITS-1:0] seg_sel_in,
    output logic [SEG_W-1:0]      sample_seg,
    output logic [NUM_DIGITS-1:0] sample_sel,
    output logic                  capture
);

    localparam int unsigned    RUN_W   = $clog2(SETTLE + 2);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(SETTLE + 1);
    localparam logic [RUN_W-1:0] RUN_CAP = RUN_W'(SETTLE);

    logic [RUN_W-1:0]      run;
    logic [NUM_DIGITS-1:0] sel_active;

    assign sel_active = ~seg_sel_in;

    // Saturating one past SETTLE keeps capture from re-firing on a long hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            sample_seg <= '0;
            sample_sel <= '0;
            run        <= '0;
        end else begin
            sample_seg <= seg_in;
            sample_sel <= sel_active;
            if (seg_in == sample_seg && sel_active == sample_sel) begin
                if (run != RUN_MAX) begin
                    run <= run + 1'b1;
                end
            end else begin
                run <= RUN_W'(1);
            end
        end
    end

    assign capture = (run == RUN_CAP);

endmodule

// File: rtl/seven_seg_demux.sv
// Receive side of a multiplexed seven-segment bus: rebuilds per-digit patterns
// and flags completed scan frames and malformed selects.
module seven_seg_demux
    import seven_seg_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = DEF_NUM_DIGITS,
    parameter int unsigned SETTLE     = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [SEG_W-1:0]            seg_in,
    input  logic [NUM_DIGITS-1:0]       seg_sel_in,
    output logic [SEG_W*NUM_DIGITS-1:0] digits,
    output logic [NUM_DIGITS-1:0]       digit_valid,
    output logic                        frame_valid,
    output logic                        sel_error
);

    localparam int unsigned DIG_IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [NUM_DIGITS-1:0] ALL_SEEN = '1;

    logic [SEG_W-1:0]      sample_seg;
    logic [NUM_DIGITS-1:0] sample_sel;
    logic                  capture;
    onehot_dec_t           dec;
    logic                  in_range;
    logic [SEG_W-1:0]      bank [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] seen;

    seg_sample_filter #(
        .NUM_DIGITS (NUM_DIGITS),
        .SETTLE     (SETTLE)
    ) u_filter (
        .clk        (clk),
        .rst        (rst),
        .seg_in     (seg_in),
        .seg_sel_in (seg_sel_in),
        .sample_seg (sample_seg),
        .sample_sel (sample_sel),
        .capture    (capture)
    );

    assign dec      = onehot_to_index(MAX_SEL'(sample_sel));
    assign in_range = (dec.index < IDX_W'(NUM_DIGITS));

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                bank[i] <= '0;
            end
            digit_valid <= '0;
            seen        <= '0;
            frame_valid <= 1'b0;
            sel_error   <= 1'b0;
        end else begin
            frame_valid <= 1'b0;
            sel_error   <= 1'b0;
            if (capture) begin
                if (dec.multi) begin
                    // Ambiguous select corrupts the frame in progress.
                    sel_error <= 1'b1;
                    seen      <= '0;
                end else if (dec.valid && in_range) begin
                    bank[dec.index[DIG_IDX_W-1:0]] <= sample_seg;
                    digit_valid <= digit_valid | sample_sel;
                    if ((seen | sample_sel) == ALL_SEEN) begin
                        frame_valid <= 1'b1;
                        seen        <= '0;
                    end else begin
                        seen <= seen | sample_sel;
                    end
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digits
        assign digits[SEG_W*g +: SEG_W] = bank[g];
    end

endmodule

// File: tb/tb_seven_seg_demux.sv
// Self-checking bench: two demux instances (SETTLE=1 and SETTLE=3) share one
// stimulus stream and are compared every cycle against a behavioural model.
module tb_seven_seg_demux;
    import seven_seg_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [7:0]  seg_in;
    logic [7:0]  sel_in;
    logic [63:0] dig_a, dig_b;
    logic [7:0]  dv_a, dv_b;
    logic        fv_a, fv_b, se_a, se_b;

    seven_seg_demux #(.NUM_DIGITS(8), .SETTLE(1)) dut_s1 (
        .clk         (clk),
        .rst         (rst),
        .seg_in      (seg_in),
        .seg_sel_in  (sel_in),
        .digits      (dig_a),
        .digit_valid (dv_a),
        .frame_valid (fv_a),
        .sel_error   (se_a)
    );

    seven_seg_demux #(.NUM_DIGITS(8), .SETTLE(3)) dut_s3 (
        .clk         (clk),
        .rst         (rst),
        .seg_in      (seg_in),
        .seg_sel_in  (sel_in),
        .digits      (dig_b),
        .digit_valid (dv_b),
        .frame_valid (fv_b),
        .sel_error   (se_b)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int fv_cnt_a = 0;
    int se_cnt_a = 0;
    bit live     = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a capture happens one edge after the bus has been seen unchanged
    // for exactly SETTLE consecutive samples; it acts on that held value.
    int          settle [2] = '{1, 3};
    logic [7:0]  m_dig  [2][8];
    logic [7:0]  m_dv   [2];
    logic [7:0]  m_seen [2];
    logic        m_fv   [2];
    logic        m_se   [2];
    logic [15:0] m_last [2];
    int          m_len  [2];

    task automatic model_edge(input int m);
        logic [15:0] cur;
        logic [7:0]  sel;
        cur     = {seg_in, ~sel_in};
        m_fv[m] = 1'b0;
        m_se[m] = 1'b0;
        if (rst) begin
            for (int i = 0; i < 8; i++) m_dig[m][i] = 8'h00;
            m_dv[m]   = 8'h00;
            m_seen[m] = 8'h00;
            m_last[m] = 16'h0000;
            m_len[m]  = 0;
            return;
        end
        if (m_len[m] == settle[m]) begin
            sel = m_last[m][7:0];
            if ($countones(sel) > 1) begin
                m_se[m]   = 1'b1;
                m_seen[m] = 8'h00;
            end else if ($countones(sel) == 1) begin
                for (int i = 0; i < 8; i++) begin
                    if (sel[i]) m_dig[m][i] = m_last[m][15:8];
                end
                m_dv[m]   = m_dv[m] | sel;
                m_seen[m] = m_seen[m] | sel;
                if (m_seen[m] == 8'hFF) begin
                    m_fv[m]   = 1'b1;
                    m_seen[m] = 8'h00;
                end
            end
        end
        if (cur == m_last[m]) m_len[m]++;
        else m_len[m] = 1;
        m_last[m] = cur;
    endtask

    always @(posedge clk) begin
        model_edge(0);
        model_edge(1);
    end

    always @(negedge clk) begin
        if (live) begin
            for (int m = 0; m < 2; m++) begin
                logic [63:0] exp_dig;
                for (int i = 0; i < 8; i++) exp_dig[8*i +: 8] = m_dig[m][i];
                check(m == 0 ? "s1.digits" : "s3.digits", m == 0 ? dig_a : dig_b, exp_dig);
                check(m == 0 ? "s1.digit_valid" : "s3.digit_valid",
                      64'(m == 0 ? dv_a : dv_b), 64'(m_dv[m]));
                check(m == 0 ? "s1.frame_valid" : "s3.frame_valid",
                      64'(m == 0 ? fv_a : fv_b), 64'(m_fv[m]));
                check(m == 0 ? "s1.sel_error" : "s3.sel_error",
                      64'(m == 0 ? se_a : se_b), 64'(m_se[m]));
            end
            if (fv_a) fv_cnt_a++;
            if (se_a) se_cnt_a++;
        end
    end

    task automatic drive(input logic [7:0] seg, input logic [7:0] sel);
        @(negedge clk);
        #1;
        rst    = 1'b0;
        seg_in = seg;
        sel_in = sel;
    endtask

    task automatic reset_cycle();
        @(negedge clk);
        #1;
        rst    = 1'b1;
        seg_in = 8'h00;
        sel_in = 8'hFF;
    endtask

    task automatic scan(input int first, input int last, input logic [7:0] base);
        for (int k = first; k <= last; k++) drive(base + 8'(k), ~(8'h01 << k));
    endtask

    initial begin
        int          fv0, se0, r, hold, k;
        logic [63:0] last_frame;
        logic [7:0]  s, sel;

        rst    = 1'b1;
        seg_in = 8'h00;
        sel_in = 8'hFF;
        repeat (2) @(negedge clk);
        #1;
        rst  = 1'b0;
        live = 1'b1;
        check("reset digits", dig_a, 64'h0);
        check("reset digit_valid", 64'(dv_a), 64'h0);

        // Scan 1: digit 7 is written at the second edge after it is presented.
        scan(0, 7, 8'hC0);
        drive(8'h00, 8'hFF);
        check("scan1 no early frame", 64'(fv_a), 64'h0);
        drive(8'h00, 8'hFF);
        check("scan1 frame pulse", 64'(fv_a), 64'h1);
        check("scan1 digits", dig_a, 64'hC7C6C5C4C3C2C1C0);
        check("scan1 digit_valid", 64'(dv_a), 64'hFF);
        drive(8'h00, 8'hFF);
        check("scan1 one frame", 64'(fv_cnt_a), 64'd1);

        // Scan 2: three back-to-back frames of random glyphs.
        fv0 = fv_cnt_a;
        for (int f = 0; f < 3; f++) begin
            for (int d = 0; d < 8; d++) begin
                s = seg_encode(4'($urandom_range(0, 15)));
                last_frame[8*d +: 8] = s;
                drive(s, ~(8'h01 << d));
            end
        end
        repeat (2) drive(8'h00, 8'hFF);
        check("scan2 frames", 64'(fv_cnt_a - fv0), 64'd3);
        check("scan2 digits", dig_a, last_frame);
        check("scan2 no sel_error", 64'(se_cnt_a), 64'd0);

        // Multi-hot select mid-frame forces a full rescan.
        fv0 = fv_cnt_a;
        se0 = se_cnt_a;
        scan(0, 1, 8'hA0);
        drive(8'hEE, 8'b11110011);
        scan(2, 7, 8'hA0);
        repeat (2) drive(8'h00, 8'hFF);
        check("multihot error pulse", 64'(se_cnt_a - se0), 64'd1);
        check("multihot no frame", 64'(fv_cnt_a - fv0), 64'd0);
        check("multihot digits", dig_a, 64'hA7A6A5A4A3A2A1A0);
        scan(0, 7, 8'hB0);
        repeat (2) drive(8'h00, 8'hFF);
        check("multihot rescan frame", 64'(fv_cnt_a - fv0), 64'd1);

        // Zero-hot gap between digits is ignored.
        fv0 = fv_cnt_a;
        se0 = se_cnt_a;
        scan(0, 3, 8'h10);
        repeat (5) drive(8'h55, 8'hFF);
        scan(4, 7, 8'h10);
        repeat (2) drive(8'h00, 8'hFF);
        check("zerohot frame", 64'(fv_cnt_a - fv0), 64'd1);
        check("zerohot no error", 64'(se_cnt_a - se0), 64'd0);

        // Settle filter on the SETTLE=3 instance.
        check("s3 nothing captured yet", 64'(dv_b), 64'h0);
        repeat (2) drive(8'h5A, 8'hEF);
        repeat (3) drive(8'h00, 8'hFF);
        check("s3 glitch ignored", 64'(dv_b), 64'h0);
        drive(8'h3C, 8'hEF);
        for (int j = 1; j <= 3; j++) begin
            drive(8'h3C, 8'hEF);
            check("s3 not before 4th edge", 64'(dv_b[4]), 64'h0);
        end
        drive(8'h00, 8'hFF);
        check("s3 captured at 4th edge", 64'(dv_b), 64'h10);
        check("s3 digit 4", 64'(dig_b[39:32]), 64'h3C);

        // Reset mid-frame discards partial progress.
        scan(0, 5, 8'h60);
        reset_cycle();
        drive(8'h00, 8'hFF);
        check("midreset digits", dig_a, 64'h0);
        check("midreset digit_valid", 64'(dv_a), 64'h0);
        fv0 = fv_cnt_a;
        scan(6, 7, 8'h60);
        repeat (2) drive(8'h00, 8'hFF);
        check("midreset partial valid", 64'(dv_a), 64'hC0);
        check("midreset no frame", 64'(fv_cnt_a - fv0), 64'd0);
        scan(0, 7, 8'h70);
        repeat (2) drive(8'h00, 8'hFF);
        check("midreset fresh frame", 64'(fv_cnt_a - fv0), 64'd1);

        // Random traffic: scans with holds, stray selects, idles, resets.
        k = 0;
        for (int n = 0; n < 600; n++) begin
            r = $urandom_range(0, 99);
            if (r < 70) begin
                hold = (r < 45) ? 1 : $urandom_range(1, 5);
                s    = 8'($urandom);
                repeat (hold) drive(s, ~(8'h01 << k));
                k = (k + 1) % 8;
            end else if (r < 80) begin
                sel  = 8'($urandom);
                hold = $urandom_range(1, 4);
                repeat (hold) drive(8'($urandom), sel);
            end else if (r < 90) begin
                hold = $urandom_range(1, 6);
                repeat (hold) drive(8'($urandom), 8'hFF);
            end else if (r < 92) begin
                reset_cycle();
                k = 0;
            end else begin
                hold = $urandom_range(2, 5);
                repeat (hold) drive(8'($urandom), ~(8'h01 << k));
            end
        end
        repeat (6) drive(8'h00, 8'hFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
